// File: rtl/pattern_pwm_pkg.sv
// Shared types and default widths for the pattern_pwm scheduler.
package pattern_pwm_pkg;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RECOVER} sched_state_t;

   localparam int PAT_WIDTH_DEF = 16;
   localparam int DUTY_W_DEF    = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW:0] w_pos;
   logic        w_found;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < N; k++) begin
         // ptr + k stays below 2N, so one conditional subtract is a full wrap
         w_pos = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_pos >= (IW+1)'(N)) w_pos = w_pos - (IW+1)'(N);
         if (!w_found && i_req[w_pos[IW-1:0]]) begin
            w_found                 = 1'b1;
            o_gnt[w_pos[IW-1:0]]    = 1'b1;
            o_idx                   = w_pos[IW-1:0];
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/pattern_pwm_sched.sv
// Round-robin scheduler sharing one pattern_pwm engine between N_REQ requesters,
// with payload capture at grant, one-cycle launch pulse and a completion watchdog.
module pattern_pwm_sched
   import pattern_pwm_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int _PAT_WIDTH  = PAT_WIDTH_DEF,
   parameter int DUTY_W      = DUTY_W_DEF,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DUTY_W-1:0]     req_duty,
   input  logic [N_REQ*_PAT_WIDTH-1:0] req_pat,
   output logic [N_REQ-1:0]            gnt,
   output logic [N_REQ-1:0]            done,
   output logic [N_REQ-1:0]            err,
   output logic [$clog2(N_REQ)-1:0]    active_id,
   output logic                        idle,
   output logic                        eng_pwm_en,
   output logic [DUTY_W-1:0]           eng_duty_num,
   output logic [_PAT_WIDTH-1:0]       eng_pat,
   input  logic                        eng_busy,
   input  logic                        eng_valid,
   output sched_state_t                dbg_state
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   sched_state_t     r_state;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [WD_W-1:0]  r_wd;

   logic [N_REQ-1:0] w_arb_gnt;
   logic [ID_W-1:0]  w_arb_idx;
   logic             w_arb_any;

   rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
      .i_req (req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_wd         <= '0;
         gnt          <= '0;
         done         <= '0;
         err          <= '0;
         active_id    <= '0;
         eng_pwm_en   <= 1'b0;
         eng_duty_num <= '0;
         eng_pat      <= '0;
      end else begin
         done       <= '0;
         err        <= '0;
         eng_pwm_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A still-busy engine (e.g. after a reset mid-run) blocks new grants
               if (w_arb_any && !eng_busy) begin
                  gnt          <= w_arb_gnt;
                  active_id    <= w_arb_idx;
                  eng_duty_num <= req_duty[int'(w_arb_idx)*DUTY_W +: DUTY_W];
                  eng_pat      <= req_pat[int'(w_arb_idx)*_PAT_WIDTH +: _PAT_WIDTH];
                  r_rr_ptr     <= (w_arb_idx == ID_W'(N_REQ-1)) ? '0 : w_arb_idx + ID_W'(1);
                  r_state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               eng_pwm_en <= 1'b1;
               r_wd       <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               // gnt is one-hot on active_id, so it doubles as the done/err mask
               if (eng_valid) begin
                  done    <= gnt;
                  gnt     <= '0;
                  r_state <= S_IDLE;
               end else if (r_wd == WD_W'(TIMEOUT_CYC-1)) begin
                  err     <= gnt;
                  gnt     <= '0;
                  r_state <= S_RECOVER;
               end else begin
                  r_wd <= r_wd + WD_W'(1);
               end
            end
            S_RECOVER: begin
               if (!eng_busy) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign idle      = (r_state == S_IDLE) && !eng_busy;
   assign dbg_state = r_state;

endmodule
